// File: rtl/spgd_iteration_sequencer_if.sv
// Signal bundle between the SPGD iteration sequencer and its environment:
// run control, ADC accumulator handshake and gradient-update outputs.
interface spgd_iteration_sequencer_if #(
  parameter int SETTLE_W = 16,
  parameter int METRIC_W = 32
);
  logic                enable;
  logic [SETTLE_W-1:0] settle_cycles;
  logic [15:0]         iterations;
  logic                meas_done;
  logic [METRIC_W-1:0] meas_value;

  logic                pert_apply;
  logic                pert_sign;
  logic                meas_start;
  logic                update_valid;
  logic [METRIC_W:0]   metric_diff;
  logic [15:0]         iter_count;
  logic                busy;
  logic                seq_done;
  logic                fault;

  // Sequencer side: drives strobes and status.
  modport master (
    input  enable, settle_cycles, iterations, meas_done, meas_value,
    output pert_apply, pert_sign, meas_start, update_valid, metric_diff,
           iter_count, busy, seq_done, fault
  );

  // Environment side: perturbation driver, ADC accumulator, update logic.
  modport slave (
    output enable, settle_cycles, iterations, meas_done, meas_value,
    input  pert_apply, pert_sign, meas_start, update_valid, metric_diff,
           iter_count, busy, seq_done, fault
  );
endinterface

// File: rtl/spgd_iteration_sequencer.sv
// One SPGD iteration per pass: +delta, settle, measure J+; -delta, settle,
// measure J-; then a single update strobe carrying J+ - J-.
module spgd_iteration_sequencer #(
  parameter int SETTLE_W       = 16,
  parameter int METRIC_W       = 32,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                       adc_clk,
  input  logic                       rst,
  spgd_iteration_sequencer_if.master bus
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE,
    APPLY_P,
    SETTLE_P,
    MEAS_P,
    APPLY_N,
    SETTLE_N,
    MEAS_N,
    UPDATE,
    DONE,
    FAULT
  } state_t;

  state_t              state;
  logic [SETTLE_W-1:0] settle_lat;
  logic [15:0]         iter_lat;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [TO_W-1:0]     timeout_cnt;
  logic                meas_first;
  logic [METRIC_W-1:0] j_plus;

  // NOTE: state and registered outputs use non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge adc_clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      settle_lat       <= '0;
      iter_lat         <= '0;
      settle_cnt       <= '0;
      timeout_cnt      <= '0;
      meas_first       <= 1'b0;
      j_plus           <= '0;
      bus.pert_apply   <= 1'b0;
      bus.pert_sign    <= 1'b0;
      bus.meas_start   <= 1'b0;
      bus.update_valid <= 1'b0;
      bus.metric_diff  <= '0;
      bus.iter_count   <= '0;
      bus.busy         <= 1'b0;
      bus.seq_done     <= 1'b0;
      bus.fault        <= 1'b0;
    end else begin
      // Strobes are single-cycle unless a transition below re-asserts them.
      bus.pert_apply   <= 1'b0;
      bus.meas_start   <= 1'b0;
      bus.update_valid <= 1'b0;

      if (state != IDLE && !bus.enable) begin
        // Abort: metric_diff and iter_count deliberately keep their values.
        state         <= IDLE;
        bus.pert_sign <= 1'b0;
        bus.busy      <= 1'b0;
        bus.seq_done  <= 1'b0;
        bus.fault     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.enable) begin
              settle_lat     <= bus.settle_cycles;
              iter_lat       <= bus.iterations;
              bus.iter_count <= '0;
              bus.pert_apply <= 1'b1;
              bus.pert_sign  <= 1'b0;
              bus.busy       <= 1'b1;
              state          <= APPLY_P;
            end
          end

          APPLY_P, APPLY_N: begin
            settle_cnt <= settle_lat;
            state      <= (state == APPLY_P) ? SETTLE_P : SETTLE_N;
          end

          SETTLE_P, SETTLE_N: begin
            if (settle_cnt == '0) begin
              bus.meas_start <= 1'b1;
              meas_first     <= 1'b1;
              timeout_cnt    <= '0;
              state          <= (state == SETTLE_P) ? MEAS_P : MEAS_N;
            end else begin
              settle_cnt <= settle_cnt - SETTLE_W'(1);
            end
          end

          MEAS_P, MEAS_N: begin
            meas_first <= 1'b0;
            // A done seen in the meas_start cycle belongs to the previous run.
            if (!meas_first && bus.meas_done) begin
              if (state == MEAS_P) begin
                j_plus         <= bus.meas_value;
                bus.pert_apply <= 1'b1;
                bus.pert_sign  <= 1'b1;
                state          <= APPLY_N;
              end else begin
                bus.metric_diff  <= {1'b0, j_plus} - {1'b0, bus.meas_value};
                bus.iter_count   <= bus.iter_count + 16'd1;
                bus.update_valid <= 1'b1;
                bus.pert_sign    <= 1'b0;
                state            <= UPDATE;
              end
            end else if (timeout_cnt == TO_LAST) begin
              bus.fault     <= 1'b1;
              bus.busy      <= 1'b0;
              bus.pert_sign <= 1'b0;
              state         <= FAULT;
            end else begin
              timeout_cnt <= timeout_cnt + TO_W'(1);
            end
          end

          UPDATE: begin
            if (iter_lat != '0 && bus.iter_count == iter_lat) begin
              bus.seq_done <= 1'b1;
              bus.busy     <= 1'b0;
              state        <= DONE;
            end else begin
              bus.pert_apply <= 1'b1;
              bus.pert_sign  <= 1'b0;
              state          <= APPLY_P;
            end
          end

          DONE, FAULT: begin
            // Held until enable drops.
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spgd_iteration_sequencer.sv
// Directed bench for spgd_iteration_sequencer: reset, single iteration,
// done glitches, free-running cadence, abort, timeout and mid-run reset.
module tb_spgd_iteration_sequencer;

  localparam int SETTLE_W       = 16;
  localparam int METRIC_W       = 32;
  localparam int TIMEOUT_CYCLES = 16;

  logic adc_clk = 1'b0;
  logic rst     = 1'b0;
  always #5 adc_clk = ~adc_clk;

  spgd_iteration_sequencer_if #(.SETTLE_W(SETTLE_W), .METRIC_W(METRIC_W)) bus ();

  spgd_iteration_sequencer #(
    .SETTLE_W      (SETTLE_W),
    .METRIC_W      (METRIC_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .adc_clk(adc_clk),
    .rst    (rst),
    .bus    (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // ADC accumulator model: done k cycles after meas_start, value by sign.
  logic                resp_en    = 1'b0;
  int                  resp_k     = 3;
  logic [METRIC_W-1:0] val_p      = '0;
  logic [METRIC_W-1:0] val_n      = '0;
  logic                resp_done  = 1'b0;
  int                  resp_cnt   = 0;
  logic                force_done = 1'b0;
  logic [METRIC_W-1:0] force_val  = '0;

  assign bus.meas_done  = resp_done | force_done;
  assign bus.meas_value = resp_en ? (bus.pert_sign ? val_n : val_p) : force_val;

  always @(posedge adc_clk) begin
    #1;
    resp_done = 1'b0;
    if (!resp_en) resp_cnt = 0;
    else if (bus.meas_start) resp_cnt = resp_k;
    else if (resp_cnt != 0) begin
      resp_cnt--;
      if (resp_cnt == 0) resp_done = 1'b1;
    end
  end

  task automatic step();
    @(posedge adc_clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_vec++;
    if ({bus.pert_apply, bus.pert_sign, bus.meas_start, bus.update_valid,
         bus.busy, bus.seq_done, bus.fault} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 0000000", {bus.pert_apply, bus.pert_sign,
               bus.meas_start, bus.update_valid, bus.busy, bus.seq_done, bus.fault});
    end
    n_vec++;
    if (bus.metric_diff !== '0) begin
      n_err++;
      $display("FAIL reset_metric_diff: got %h want 0", bus.metric_diff);
    end
    n_vec++;
    if (bus.iter_count !== 16'd0) begin
      n_err++;
      $display("FAIL reset_iter_count: got %0d want 0", bus.iter_count);
    end
    rst = 1'b0;
    repeat (3) step();
    n_vec++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_busy: got %b want 0", bus.busy);
    end
  endtask

  task automatic test_single_iteration();
    int n_apply = 0, n_start = 0, n_upd = 0, upd_cyc = -1;
    logic first_apply = 1'b0, overlap = 1'b0, sign_ok = 1'b1;
    logic [METRIC_W:0] diff_seen = '0;
    logic [15:0] cnt_seen = '0;
    bus.iterations = 16'd1; bus.settle_cycles = 16'd4;
    resp_k = 3; val_p = 32'd1000; val_n = 32'd1200; resp_en = 1'b1;
    bus.enable = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (c == 1) first_apply = bus.pert_apply;
      if (int'(bus.pert_apply) + int'(bus.meas_start) + int'(bus.update_valid) > 1) overlap = 1'b1;
      if (bus.pert_apply) begin
        n_apply++;
        if (bus.pert_sign !== (n_apply == 2)) sign_ok = 1'b0;
      end
      if (bus.meas_start) begin
        n_start++;
        if (bus.pert_sign !== (n_start == 2)) sign_ok = 1'b0;
      end
      if (bus.update_valid) begin
        n_upd++;
        if (upd_cyc < 0) upd_cyc = c;
        diff_seen = bus.metric_diff;
        cnt_seen  = bus.iter_count;
      end
    end
    n_vec++;
    if (first_apply !== 1'b1) begin n_err++; $display("FAIL single_first_apply: got %b want 1", first_apply); end
    n_vec++;
    if (n_apply != 2 || n_start != 2) begin
      n_err++; $display("FAIL single_strobes: got apply=%0d start=%0d want 2/2", n_apply, n_start);
    end
    n_vec++;
    if (sign_ok !== 1'b1 || overlap !== 1'b0) begin
      n_err++; $display("FAIL single_sign_overlap: got sign_ok=%b overlap=%b want 1/0", sign_ok, overlap);
    end
    n_vec++;
    if (n_upd != 1 || upd_cyc != 21) begin
      n_err++; $display("FAIL single_update: got n=%0d at cycle %0d want 1 at 21", n_upd, upd_cyc);
    end
    n_vec++;
    if (diff_seen !== 33'h1_FFFF_FF38) begin
      n_err++; $display("FAIL single_metric_diff: got %h want 1ffffff38", diff_seen);
    end
    n_vec++;
    if (cnt_seen !== 16'd1) begin n_err++; $display("FAIL single_iter_count: got %0d want 1", cnt_seen); end
    n_vec++;
    if (bus.seq_done !== 1'b1 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL single_done: got seq_done=%b busy=%b want 1/0", bus.seq_done, bus.busy);
    end
    bus.enable = 1'b0;
    step();
    n_vec++;
    if (bus.seq_done !== 1'b0 || bus.busy !== 1'b0 || bus.iter_count !== 16'd1) begin
      n_err++; $display("FAIL single_exit: got seq_done=%b busy=%b iter=%0d want 0/0/1",
                        bus.seq_done, bus.busy, bus.iter_count);
    end
  endtask

  // Entered in an APPLY cycle; done held high through APPLY, SETTLE and the
  // first MEAS cycle, then a real done is given in the fourth MEAS cycle.
  task automatic glitch_half(input logic [METRIC_W-1:0] gval, input logic [METRIC_W-1:0] rval);
    logic early = 1'b0;
    force_done = 1'b1; force_val = gval;
    for (int i = 1; i <= 5; i++) begin
      step();
      if (bus.meas_start || bus.pert_apply || bus.update_valid) early = 1'b1;
    end
    n_vec++;
    if (early !== 1'b0) begin n_err++; $display("FAIL glitch_settle: got early advance want none"); end
    step();
    n_vec++;
    if (bus.meas_start !== 1'b1) begin n_err++; $display("FAIL glitch_meas_start: got %b want 1", bus.meas_start); end
    step();
    force_done = 1'b0;
    n_vec++;
    if (bus.pert_apply !== 1'b0 || bus.update_valid !== 1'b0 || bus.busy !== 1'b1) begin
      n_err++; $display("FAIL glitch_first_meas: got apply=%b upd=%b busy=%b want 0/0/1",
                        bus.pert_apply, bus.update_valid, bus.busy);
    end
    step();
    step();
    force_done = 1'b1; force_val = rval;
    step();
    force_done = 1'b0;
  endtask

  task automatic test_done_glitches();
    resp_en = 1'b0; force_done = 1'b0;
    bus.iterations = 16'd1; bus.settle_cycles = 16'd4;
    bus.enable = 1'b1;
    step();
    glitch_half(32'd7, 32'd500);
    n_vec++;
    if (bus.pert_apply !== 1'b1 || bus.pert_sign !== 1'b1) begin
      n_err++; $display("FAIL glitch_apply_n: got apply=%b sign=%b want 1/1", bus.pert_apply, bus.pert_sign);
    end
    glitch_half(32'd9999, 32'd200);
    n_vec++;
    if (bus.update_valid !== 1'b1 || bus.metric_diff !== 33'd300) begin
      n_err++; $display("FAIL glitch_update: got valid=%b diff=%h want 1/12c", bus.update_valid, bus.metric_diff);
    end
    step();
    n_vec++;
    if (bus.seq_done !== 1'b1) begin n_err++; $display("FAIL glitch_done: got %b want 1", bus.seq_done); end
    bus.enable = 1'b0;
    step();
  endtask

  task automatic test_free_running_and_abort();
    int n_upd = 0, last = 0, n_late = 0;
    logic found = 1'b0;
    resp_en = 1'b1; resp_k = 3; val_p = 32'd5000; val_n = 32'd4000;
    bus.iterations = 16'd0; bus.settle_cycles = 16'd4;
    bus.enable = 1'b1;
    for (int c = 1; c <= 200 && n_upd < 6; c++) begin
      step();
      if (bus.update_valid) begin
        n_upd++;
        n_vec++;
        if (c - last != 21 || bus.iter_count !== 16'(n_upd) || bus.metric_diff !== 33'd1000) begin
          n_err++; $display("FAIL free_update%0d: got gap=%0d iter=%0d diff=%h want 21/%0d/3e8",
                            n_upd, c - last, bus.iter_count, bus.metric_diff, n_upd);
        end
        last = c;
      end
    end
    n_vec++;
    if (n_upd != 6) begin n_err++; $display("FAIL free_count: got %0d updates want 6", n_upd); end
    // Abort in MEAS_N of the next iteration with a different J+ pending.
    val_p = 32'd77;
    for (int c = 0; c < 60 && !found; c++) begin
      step();
      if (bus.meas_start && bus.pert_sign) found = 1'b1;
    end
    n_vec++;
    if (!found) begin n_err++; $display("FAIL abort_reach_meas_n: got timeout want meas_start"); end
    step();
    bus.enable = 1'b0;
    step();
    n_vec++;
    if (bus.busy !== 1'b0 || bus.pert_sign !== 1'b0) begin
      n_err++; $display("FAIL abort_idle: got busy=%b sign=%b want 0/0", bus.busy, bus.pert_sign);
    end
    for (int c = 0; c < 40; c++) begin
      step();
      if (bus.update_valid || bus.pert_apply || bus.meas_start) n_late++;
    end
    n_vec++;
    if (n_late != 0 || bus.metric_diff !== 33'd1000 || bus.iter_count !== 16'd6) begin
      n_err++; $display("FAIL abort_hold: got strobes=%0d diff=%h iter=%0d want 0/3e8/6",
                        n_late, bus.metric_diff, bus.iter_count);
    end
  endtask

  task automatic test_timeout();
    resp_en = 1'b0; force_done = 1'b0;
    bus.iterations = 16'd1; bus.settle_cycles = 16'd0;
    bus.enable = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      step();
      if (c == 3) begin
        n_vec++;
        if (bus.meas_start !== 1'b1) begin n_err++; $display("FAIL timeout_start: got %b want 1", bus.meas_start); end
      end
      if (c == 18) begin
        n_vec++;
        if (bus.fault !== 1'b0 || bus.busy !== 1'b1) begin
          n_err++; $display("FAIL timeout_early: got fault=%b busy=%b want 0/1", bus.fault, bus.busy);
        end
      end
      if (c == 19 || c == 22) begin
        n_vec++;
        if (bus.fault !== 1'b1 || bus.busy !== 1'b0) begin
          n_err++; $display("FAIL timeout_fault_c%0d: got fault=%b busy=%b want 1/0", c, bus.fault, bus.busy);
        end
      end
    end
    bus.enable = 1'b0;
    step();
    n_vec++;
    if (bus.fault !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL timeout_clear: got fault=%b busy=%b want 0/0", bus.fault, bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    logic found = 1'b0;
    int n_act = 0;
    resp_en = 1'b1; resp_k = 3;
    bus.iterations = 16'd0; bus.settle_cycles = 16'd4;
    bus.enable = 1'b1;
    for (int c = 0; c < 40 && !found; c++) begin
      step();
      if (bus.pert_apply && bus.pert_sign) found = 1'b1;
    end
    step();
    step();
    n_vec++;
    if (!found || bus.busy !== 1'b1 || bus.metric_diff !== 33'd1000) begin
      n_err++; $display("FAIL rstmid_pre: got found=%b busy=%b diff=%h want 1/1/3e8", found, bus.busy, bus.metric_diff);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({bus.pert_apply, bus.pert_sign, bus.meas_start, bus.update_valid,
         bus.busy, bus.seq_done, bus.fault} !== 7'b0 || bus.metric_diff !== '0 || bus.iter_count !== 16'd0) begin
      n_err++; $display("FAIL rstmid_outputs: got busy=%b diff=%h iter=%0d want 0/0/0",
                        bus.busy, bus.metric_diff, bus.iter_count);
    end
    bus.enable = 1'b0;
    step();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (bus.busy || bus.pert_apply) n_act++;
    end
    n_vec++;
    if (n_act != 0) begin n_err++; $display("FAIL rstmid_idle: got %0d active cycles want 0", n_act); end
  endtask

  initial begin
    bus.enable        = 1'b0;
    bus.settle_cycles = '0;
    bus.iterations    = '0;
    #1;
    test_reset();
    test_single_iteration();
    test_done_glitches();
    test_free_running_and_abort();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
